// File: rtl/uart_reg_alu_system.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_alu_system
// Purpose  : UART command processor. It receives framed bytes (start, 8 data
//            bits LSB first, even parity, stop) and uses them to write or read
//            a register file, or to run an ALU on registers 0 and 1. Register
//            bytes and ALU results go back through a TX FIFO and a UART
//            transmitter that uses the same frame format.
// Ports    : i_ref_clk    - sole clock, rising edge
//            i_rst_n      - asynchronous active-low reset
//            i_rx_in      - serial input, idle high
//            o_tx_out     - serial output, idle high
//            o_parity_err - last received frame had a parity mismatch
//            o_stop_err   - last received frame had a low stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_alu_system #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic i_ref_clk,
  input  logic i_rst_n,
  input  logic i_rx_in,
  output logic o_tx_out,
  output logic o_parity_err,
  output logic o_stop_err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_WIDTH + 3);
  localparam int RES_W  = 2 * DATA_WIDTH;
  localparam int NREGS  = 1 << ADDR_WIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]      C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      C_HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]      C_STOP_IDX = IDX_W'(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0]      C_TX_BITS  = IDX_W'(DATA_WIDTH + 2);
  localparam logic [PTR_W-1:0]      C_PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0]     C_FIFO_MAX = FCNT_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] C_OP_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] C_OP_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] C_OP_LOAD  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] C_OP_FUNC  = DATA_WIDTH'(8'hDD);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
  typedef enum logic [2:0] {CMD_IDLE, CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR,
                            CMD_OPA, CMD_OPB, CMD_FUNC} cmd_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  // ---------------- RX ----------------
  rx_state_t               rx_state_q;
  logic                    rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]        rx_cnt_q;
  logic [IDX_W-1:0]        rx_idx_q;
  logic [DATA_WIDTH:0]     rx_shift_q;   // data bits plus the parity bit
  logic                    rx_valid_q;
  logic [DATA_WIDTH-1:0]   rx_byte_q;
  logic                    parity_err_q, stop_err_q;
  logic                    w_rx_perr;

  assign w_rx_perr = rx_shift_q[DATA_WIDTH] ^ (^rx_shift_q[DATA_WIDTH-1:0]);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= '0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx_in;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          // A real falling edge is required, so a line held low after a
          // broken stop bit does not start a spurious frame.
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == C_HALF_BIT) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_BITS;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_BITS: begin
          if (rx_cnt_q == C_BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_idx_q == C_STOP_IDX) begin
              parity_err_q <= w_rx_perr;
              stop_err_q   <= ~rx_sync_q;
              rx_valid_q   <= ~w_rx_perr & rx_sync_q;
              rx_byte_q    <= rx_shift_q[DATA_WIDTH-1:0];
              rx_state_q   <= RX_IDLE;
            end else begin
              rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_WIDTH:1]};
              rx_idx_q   <= rx_idx_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- ALU ----------------
  logic [DATA_WIDTH-1:0] w_a, w_b;
  logic [RES_W-1:0]      w_a_ext, w_b_ext, w_alu;
  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  assign w_a     = regs_q[0];
  assign w_b     = regs_q[1];
  assign w_a_ext = RES_W'(w_a);
  assign w_b_ext = RES_W'(w_b);

  always_comb begin
    w_alu = '0;
    case (rx_byte_q[3:0])
      4'd0:  w_alu = w_a_ext + w_b_ext;
      4'd1:  w_alu = w_a_ext - w_b_ext;
      4'd2:  w_alu = w_a_ext * w_b_ext;
      4'd3:  w_alu = (w_b == '0) ? '0 : w_a_ext / w_b_ext;
      4'd4:  w_alu = RES_W'(w_a & w_b);
      4'd5:  w_alu = RES_W'(w_a | w_b);
      4'd6:  w_alu = RES_W'(~(w_a & w_b));
      4'd7:  w_alu = RES_W'(~(w_a | w_b));
      4'd8:  w_alu = RES_W'(w_a ^ w_b);
      4'd9:  w_alu = RES_W'(~(w_a ^ w_b));
      4'd10: w_alu = (w_a == w_b) ? RES_W'(1) : '0;
      4'd11: w_alu = (w_a > w_b)  ? RES_W'(2) : '0;
      4'd12: w_alu = (w_a < w_b)  ? RES_W'(3) : '0;
      4'd13: w_alu = w_a_ext >> 1;
      4'd14: w_alu = w_a_ext << 1;
      default: w_alu = '0;
    endcase
  end

  // ---------------- Command FSM ----------------
  cmd_state_t            cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  hi_pend_q;
  logic [DATA_WIDTH-1:0] hi_byte_q;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_push_data;

  // The upper ALU byte is parked for one cycle so the two result bytes
  // enter the FIFO on consecutive cycles.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (hi_pend_q) begin
      w_push      = 1'b1;
      w_push_data = hi_byte_q;
    end else if (rx_valid_q && cmd_q == CMD_RD_ADDR) begin
      w_push      = 1'b1;
      w_push_data = regs_q[rx_byte_q[ADDR_WIDTH-1:0]];
    end else if (rx_valid_q && cmd_q == CMD_FUNC) begin
      w_push      = 1'b1;
      w_push_data = w_alu[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_q     <= CMD_IDLE;
      addr_q    <= '0;
      hi_pend_q <= 1'b0;
      hi_byte_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      hi_pend_q <= 1'b0;
      if (rx_valid_q) begin
        case (cmd_q)
          CMD_IDLE: begin
            if      (rx_byte_q == C_OP_WRITE) cmd_q <= CMD_WR_ADDR;
            else if (rx_byte_q == C_OP_READ)  cmd_q <= CMD_RD_ADDR;
            else if (rx_byte_q == C_OP_LOAD)  cmd_q <= CMD_OPA;
            else if (rx_byte_q == C_OP_FUNC)  cmd_q <= CMD_FUNC;
          end
          CMD_WR_ADDR: begin
            addr_q <= rx_byte_q[ADDR_WIDTH-1:0];
            cmd_q  <= CMD_WR_DATA;
          end
          CMD_WR_DATA: begin
            regs_q[addr_q] <= rx_byte_q;
            cmd_q          <= CMD_IDLE;
          end
          CMD_RD_ADDR: cmd_q <= CMD_IDLE;
          CMD_OPA: begin
            regs_q[0] <= rx_byte_q;
            cmd_q     <= CMD_OPB;
          end
          CMD_OPB: begin
            regs_q[1] <= rx_byte_q;
            cmd_q     <= CMD_FUNC;
          end
          CMD_FUNC: begin
            hi_pend_q <= 1'b1;
            hi_byte_q <= w_alu[RES_W-1:DATA_WIDTH];
            cmd_q     <= CMD_IDLE;
          end
          default: cmd_q <= CMD_IDLE;
        endcase
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]     fifo_cnt_q;
  logic                  w_fifo_empty, w_fifo_full, w_fifo_push, w_tx_pop;

  assign w_fifo_empty = (fifo_cnt_q == '0);
  assign w_fifo_full  = (fifo_cnt_q == C_FIFO_MAX);
  // A simultaneous pop frees a slot, so a push into a full FIFO is kept then.
  assign w_fifo_push  = w_push & (~w_fifo_full | w_tx_pop);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      if (w_fifo_push) begin
        fifo_mem_q[wr_ptr_q] <= w_push_data;
        wr_ptr_q <= (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_tx_pop) begin
        rd_ptr_q <= (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({w_fifo_push, w_tx_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------- TX ----------------
  tx_state_t             tx_state_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic [IDX_W-1:0]      tx_left_q;
  logic [DATA_WIDTH+1:0] tx_shift_q;   // {stop, parity, data}
  logic                  tx_q;
  logic [DATA_WIDTH-1:0] w_tx_byte;

  assign w_tx_byte = fifo_mem_q[rd_ptr_q];
  // Pop when idle, or at the very end of a stop bit so frames run back to back.
  assign w_tx_pop  = ~w_fifo_empty &
                     ((tx_state_q == TX_IDLE) |
                      (tx_cnt_q == C_BIT_LAST && tx_left_q == '0));

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_left_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else if (w_tx_pop) begin
      tx_state_q <= TX_BUSY;
      tx_cnt_q   <= '0;
      tx_left_q  <= C_TX_BITS;
      tx_shift_q <= {1'b1, ^w_tx_byte, w_tx_byte};
      tx_q       <= 1'b0;
    end else if (tx_state_q == TX_BUSY) begin
      if (tx_cnt_q == C_BIT_LAST) begin
        tx_cnt_q <= '0;
        if (tx_left_q == '0) begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
          tx_left_q  <= tx_left_q - 1'b1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  assign o_tx_out     = tx_q;
  assign o_parity_err = parity_err_q;
  assign o_stop_err   = stop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_alu_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_reg_alu_system
// Purpose  : Self-checking bench for uart_reg_alu_system. Expected TX bytes
//            are queued when commands are sent; a TX monitor decodes frames
//            and compares each against the head of the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_alu_system;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tx, perr, serr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];

  uart_reg_alu_system #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_rx_in     (rx),
    .o_tx_out    (tx),
    .o_parity_err(perr),
    .o_stop_err  (serr)
  );

  always #5 clk = ~clk;

  // ---------------- TX monitor / scoreboard ----------------
  logic [7:0] mon_d;
  logic       mon_p, mon_s;
  logic [7:0] mon_e;

  initial begin
    forever begin
      @(negedge tx);
      if (rst_n === 1'b1) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_d[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          mon_p = tx;
          repeat (CPB) @(negedge clk);
          mon_s = tx;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got byte %02h, expected no transmission", mon_d);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_d !== mon_e) begin
              n_fail++;
              $display("FAIL tx_data: got %02h, expected %02h", mon_d, mon_e);
            end
            n_tests++;
            if (mon_p !== ^mon_e) begin
              n_fail++;
              $display("FAIL tx_parity (byte %02h): got %b, expected %b", mon_e, mon_p, ^mon_e);
            end
            n_tests++;
            if (mon_s !== 1'b1) begin
              n_fail++;
              $display("FAIL tx_stop (byte %02h): got %b, expected 1", mon_e, mon_s);
            end
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_byte(d, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    n_tests++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b, expected 0", perr); end
    n_tests++;
    if (serr !== 1'b0) begin n_fail++; $display("FAIL reset_serr: got %b, expected 0", serr); end
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    exp_q.push_back(8'h00);
    send_ok(8'hBB); send_ok(8'h03);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_reset_read: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_write_read();
    bit ok;
    send_ok(8'hAA); send_ok(8'h04); send_ok(8'h8F);
    send_ok(8'hAA); send_ok(8'h05); send_ok(8'hA5);
    send_ok(8'hAA); send_ok(8'h07); send_ok(8'hBC);
    exp_q.push_back(8'h8F); send_ok(8'hBB); send_ok(8'h04);
    exp_q.push_back(8'hA5); send_ok(8'hBB); send_ok(8'h05);
    exp_q.push_back(8'hBC); send_ok(8'hBB); send_ok(8'hF7);  // upper address bits ignored
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_write_read: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_alu();
    bit ok;
    send_ok(8'hCC); send_ok(8'd100); send_ok(8'd50);
    exp_q.push_back(8'h96); exp_q.push_back(8'h00); send_ok(8'h00);
    exp_q.push_back(8'h32); exp_q.push_back(8'h00); send_ok(8'hDD); send_ok(8'h01);
    exp_q.push_back(8'h88); exp_q.push_back(8'h13); send_ok(8'hDD); send_ok(8'h02);
    exp_q.push_back(8'h02); exp_q.push_back(8'h00); send_ok(8'hDD); send_ok(8'h03);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_alu: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_div_zero();
    bit ok;
    send_ok(8'hCC); send_ok(8'd7); send_ok(8'd0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); send_ok(8'h03);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); send_ok(8'hDD); send_ok(8'h0C);
    exp_q.push_back(8'h02); exp_q.push_back(8'h00); send_ok(8'hDD); send_ok(8'h0B);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_div_zero: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_parity_err();
    bit ok;
    send_byte(8'hAA, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    n_tests++;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL parity_flag_set: got %b, expected 1", perr); end
    n_tests++;
    if (serr !== 1'b0) begin n_fail++; $display("FAIL parity_case_serr: got %b, expected 0", serr); end
    exp_q.push_back(8'hA5);
    send_ok(8'hBB); send_ok(8'h05);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_parity: got %0d pending, expected 0", exp_q.size()); end
    n_tests++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL parity_flag_clear: got %b, expected 0", perr); end
  endtask

  task automatic test_stop_err();
    bit ok;
    send_byte(8'hBB, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    n_tests++;
    if (serr !== 1'b1) begin n_fail++; $display("FAIL stop_flag_set: got %b, expected 1", serr); end
    // Had the bad 0xBB been accepted, this would read reg 7 and transmit.
    send_ok(8'h07);
    repeat (4) @(negedge clk);
    n_tests++;
    if (serr !== 1'b0) begin n_fail++; $display("FAIL stop_flag_clear: got %b, expected 0", serr); end
    repeat (CPB * 14) @(negedge clk);
    exp_q.push_back(8'h8F);
    send_ok(8'hBB); send_ok(8'h04);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_stop: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    bit ok;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB * 14) @(negedge clk);
    n_tests++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL glitch_perr: got %b, expected 0", perr); end
    n_tests++;
    if (serr !== 1'b0) begin n_fail++; $display("FAIL glitch_serr: got %b, expected 0", serr); end
    exp_q.push_back(8'hBC);
    send_ok(8'hBB); send_ok(8'h07);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_glitch: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] d;
    send_ok(8'hAA); send_ok(8'h08);
    send_byte(8'h11, 1'b1, 1'b0);     // discarded; FSM still waits for data
    repeat (4) @(negedge clk);
    n_tests++;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_perr: got %b, expected 1", perr); end
    d = 8'h55;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b, expected 1", tx); end
    n_tests++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: got %b, expected 0", perr); end
    n_tests++;
    if (serr !== 1'b0) begin n_fail++; $display("FAIL midrst_serr: got %b, expected 0", serr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB * 2) @(negedge clk);
    exp_q.push_back(8'h00); send_ok(8'hBB); send_ok(8'h08);
    exp_q.push_back(8'h00); send_ok(8'hBB); send_ok(8'h04);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drain_midrst: got %0d pending, expected 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_write_read();
    test_alu();
    test_div_zero();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_reset_mid_frame();
    repeat (CPB * 30) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
